axi_chan_buffer: RTL and testbench

//  Parametrised single-clock buffer for one AXI4 channel (AW/W/B/AR/R payload packed by the caller).

---
 rtl/axi_chan_buffer.sv | 100 ++++++++++
 tb/tb_axi_chan_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_chan_buffer.sv
// Single-clock buffer for one AXI4 channel: register slice, FIFO or packet FIFO.
// Storage is a flop array read at the head pointer, so the head beat is visible the cycle after its write.
module axi_chan_buffer #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MODE      = 1,
  parameter int unsigned AFULL_THR = 12
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic [DATA_W-1:0]          s_axi_payload,
  input  logic                       s_axi_last,
  input  logic                       s_axi_valid,
  output logic                       s_axi_ready,
  output logic [DATA_W-1:0]          m_axi_payload,
  output logic                       m_axi_last,
  output logic                       m_axi_valid,
  input  logic                       m_axi_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);

  // MODE 0 is a main+skid pair, i.e. a two-entry queue with a registered ready.
  localparam int unsigned CAP = (MODE == 0) ? 2 : DEPTH;
  localparam int unsigned THR = (MODE == 0) ? 2 : AFULL_THR;
  localparam int unsigned AW  = $clog2(CAP);
  localparam int unsigned LW  = $clog2(DEPTH + 1);

  localparam logic [LW-1:0] CapLvl = LW'(CAP);
  localparam logic [LW-1:0] ThrLvl = LW'(THR);
  localparam logic [AW:0]   PtrOne = (AW + 1)'(1);

  logic [DATA_W:0] r_mem [CAP];
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level, w_level_d;
  logic [LW-1:0]   r_pkt_cnt, w_pkt_cnt_d;
  logic            r_ready, r_afull, r_drain;
  logic            w_push, w_pop, w_head, w_valid;
  logic [DATA_W:0] w_head_beat;

  assign w_head_beat = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head      = (r_level != '0);

  // Packet mode holds the head back until a whole burst is stored, unless the FIFO filled first.
  always_comb begin
    w_valid = w_head;
    if (MODE == 2) begin
      w_valid = w_head & ((r_pkt_cnt != '0) | r_drain);
    end
  end

  assign w_push    = s_axi_valid & r_ready;
  assign w_pop     = w_valid & m_axi_ready;
  assign w_level_d = r_level + LW'(w_push) - LW'(w_pop);

  always_comb begin
    w_pkt_cnt_d = r_pkt_cnt;
    case ({w_push & s_axi_last, w_pop & m_axi_last})
      2'b10:   w_pkt_cnt_d = r_pkt_cnt + LW'(1);
      2'b01:   w_pkt_cnt_d = r_pkt_cnt - LW'(1);
      default: w_pkt_cnt_d = r_pkt_cnt;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_pkt_cnt <= '0;
      r_ready   <= 1'b0;
      r_afull   <= 1'b0;
      r_drain   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      r_level   <= w_level_d;
      r_pkt_cnt <= w_pkt_cnt_d;
      r_ready   <= (w_level_d < CapLvl);
      r_afull   <= (w_level_d >= ThrLvl);
      if (w_pop && m_axi_last) begin
        r_drain <= 1'b0;
      end else if (r_level == CapLvl && r_pkt_cnt == '0) begin
        r_drain <= 1'b1;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {s_axi_last, s_axi_payload};
  end

  assign s_axi_ready   = r_ready;
  assign m_axi_valid   = w_valid;
  assign m_axi_last    = w_valid & w_head_beat[DATA_W];
  assign m_axi_payload = w_valid ? w_head_beat[DATA_W-1:0] : '0;
  assign level         = r_level;
  assign almost_full   = r_afull;

endmodule

// File: tb/tb_axi_chan_buffer.sv
// Bench for axi_chan_buffer: one instance per mode, scoreboard queues checked as beats leave.
module tb_axi_chan_buffer;
  localparam int DW = 32;
  typedef logic [DW:0] beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sp [3];
  logic          sl [3];
  logic          sv [3];
  logic          sr [3];
  logic [DW-1:0] mp [3];
  logic          ml [3];
  logic          mv [3];
  logic          mr [3];
  logic [4:0]    lvl [3];
  logic          af [3];

  beat_t q0[$], q1[$], q2[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_chan_buffer #(.DATA_W(DW), .DEPTH(16), .MODE(0), .AFULL_THR(12)) u_m0 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_payload(sp[0]), .s_axi_last(sl[0]), .s_axi_valid(sv[0]), .s_axi_ready(sr[0]),
    .m_axi_payload(mp[0]), .m_axi_last(ml[0]), .m_axi_valid(mv[0]), .m_axi_ready(mr[0]),
    .level(lvl[0]), .almost_full(af[0])
  );
  axi_chan_buffer #(.DATA_W(DW), .DEPTH(16), .MODE(1), .AFULL_THR(12)) u_m1 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_payload(sp[1]), .s_axi_last(sl[1]), .s_axi_valid(sv[1]), .s_axi_ready(sr[1]),
    .m_axi_payload(mp[1]), .m_axi_last(ml[1]), .m_axi_valid(mv[1]), .m_axi_ready(mr[1]),
    .level(lvl[1]), .almost_full(af[1])
  );
  axi_chan_buffer #(.DATA_W(DW), .DEPTH(16), .MODE(2), .AFULL_THR(12)) u_m2 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_payload(sp[2]), .s_axi_last(sl[2]), .s_axi_valid(sv[2]), .s_axi_ready(sr[2]),
    .m_axi_payload(mp[2]), .m_axi_last(ml[2]), .m_axi_valid(mv[2]), .m_axi_ready(mr[2]),
    .level(lvl[2]), .almost_full(af[2])
  );

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b1; sl[k] = 1'b1; sp[k] = $urandom; mr[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({sr[k], mv[k], ml[k], af[k], lvl[k], mp[k]} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", k,
                 {sr[k], mv[k], ml[k], af[k], lvl[k], mp[k]});
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (sr[k] !== 1'b1 || lvl[k] !== 5'd0 || mv[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release[%0d]: got ready=%b level=%0d valid=%b want 1/0/0",
                 k, sr[k], lvl[k], mv[k]);
      end
      sv[k] = 1'b0;
    end
  endtask

  // Streams 64 beats through the slice; stall_at<0 means no downstream stall.
  task automatic test_mode0_stream(input int base, input int stall_at);
    int i = 0;
    int popped = 0;
    int cyc = 0;
    beat_t e;
    while (popped < 64 && cyc < 200) begin
      @(negedge clk);
      sv[0] = (i < 64); sp[0] = 32'(base + i); sl[0] = (i % 4 == 3);
      mr[0] = (cyc != stall_at);
      #1;
      if (cyc == stall_at) begin
        n_vec++;
        if (sr[0] !== 1'b1) begin
          n_err++;
          $display("FAIL m0_stall_ready: got %b want 1", sr[0]);
        end
      end
      if (mv[0] && mr[0]) begin
        n_vec++;
        popped++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL m0_data: got %h want <no beat>", {ml[0], mp[0]});
        end else begin
          e = q0.pop_front();
          if ({ml[0], mp[0]} !== e) begin
            n_err++;
            $display("FAIL m0_data: got %h want %h", {ml[0], mp[0]}, e);
          end
        end
      end
      if (sv[0] && sr[0]) begin
        q0.push_back({sl[0], sp[0]});
        i++;
      end
      cyc++;
    end
    sv[0] = 1'b0;
    if (stall_at < 0) begin
      n_vec++;
      if (cyc != 65) begin
        n_err++;
        $display("FAIL m0_throughput: got %0d cycles want 65", cyc);
      end
    end
    n_vec++;
    if (popped != 64 || q0.size() != 0) begin
      n_err++;
      $display("FAIL m0_count: got %0d popped, %0d left want 64, 0", popped, q0.size());
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (lvl[0] !== 5'd0 || mv[0] !== 1'b0) begin
      n_err++;
      $display("FAIL m0_empty: got level=%0d valid=%b want 0/0", lvl[0], mv[0]);
    end
  endtask

  // Fill to full with no pops, one pop, then drain; level model checked every cycle.
  task automatic test_mode1_fill();
    logic [4:0] le = '0;
    beat_t e;
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      sv[1] = (c < 17); sp[1] = 32'(1000 + c); sl[1] = (c % 2 == 1);
      mr[1] = (c == 17) || (c > 18);
      #1;
      n_vec++;
      if (lvl[1] !== le || af[1] !== (le >= 5'd12) || sr[1] !== (le < 5'd16)
          || mv[1] !== (le != 5'd0)) begin
        n_err++;
        $display("FAIL m1_fill_state c=%0d: got lvl=%0d af=%b rdy=%b vld=%b want lvl=%0d",
                 c, lvl[1], af[1], sr[1], mv[1], le);
      end
      if (c == 18) begin
        n_vec++;
        if (sr[1] !== 1'b1 || lvl[1] !== 5'd15) begin
          n_err++;
          $display("FAIL m1_pop_frees: got rdy=%b lvl=%0d want 1/15", sr[1], lvl[1]);
        end
      end
      if (mv[1] && mr[1]) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL m1_fill_data: got %h want <no beat>", {ml[1], mp[1]});
        end else begin
          e = q1.pop_front();
          if ({ml[1], mp[1]} !== e) begin
            n_err++;
            $display("FAIL m1_fill_data: got %h want %h", {ml[1], mp[1]}, e);
          end
        end
        le = le - 5'd1;
      end
      if (sv[1] && sr[1]) begin
        q1.push_back({sl[1], sp[1]});
        le = le + 5'd1;
      end
    end
    sv[1] = 1'b0; mr[1] = 1'b0;
  endtask

  // Full with push+pop, drain to empty, then random traffic well past pointer wrap.
  task automatic test_mode1_wrap();
    logic [4:0] le = '0;
    beat_t e;
    int i = 0;
    int cyc = 0;
    while ((i < 48 || q1.size() != 0) && cyc < 400) begin
      @(negedge clk);
      if (cyc < 18) begin
        sv[1] = 1'b1; mr[1] = 1'b0;
      end else if (cyc < 40) begin
        sv[1] = 1'b1; mr[1] = 1'b1;
      end else if (cyc < 60) begin
        sv[1] = 1'b0; mr[1] = 1'b1;
      end else begin
        sv[1] = (i < 48) && ($urandom_range(0, 2) != 0);
        mr[1] = ($urandom_range(0, 2) != 0);
      end
      sv[1] = sv[1] && (i < 48);
      sp[1] = 32'(2000 + i); sl[1] = (i % 3 == 2);
      #1;
      n_vec++;
      if (lvl[1] !== le || af[1] !== (le >= 5'd12) || sr[1] !== (le < 5'd16)
          || mv[1] !== (le != 5'd0)) begin
        n_err++;
        $display("FAIL m1_wrap_state cyc=%0d: got lvl=%0d af=%b rdy=%b vld=%b want lvl=%0d",
                 cyc, lvl[1], af[1], sr[1], mv[1], le);
      end
      if (mv[1] && mr[1]) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL m1_wrap_data: got %h want <no beat>", {ml[1], mp[1]});
        end else begin
          e = q1.pop_front();
          if ({ml[1], mp[1]} !== e) begin
            n_err++;
            $display("FAIL m1_wrap_data: got %h want %h", {ml[1], mp[1]}, e);
          end
        end
        le = le - 5'd1;
      end
      if (sv[1] && sr[1]) begin
        q1.push_back({sl[1], sp[1]});
        le = le + 5'd1;
        i++;
      end
      cyc++;
    end
    sv[1] = 1'b0; mr[1] = 1'b0;
    n_vec++;
    if (i != 48 || q1.size() != 0) begin
      n_err++;
      $display("FAIL m1_wrap_done: got %0d pushed, %0d pending want 48, 0", i, q1.size());
    end
  endtask

  // One burst of len beats into the packet FIFO with ready held high.
  task automatic test_mode2_burst(input int len, input int base, input int want_first,
                                  input int want_lvl);
    beat_t e;
    int i = 0;
    int popped = 0;
    int cyc = 0;
    int first = -1;
    int first_lvl = -1;
    mr[2] = 1'b1;
    while (popped < len && cyc < 120) begin
      @(negedge clk);
      sv[2] = (i < len); sp[2] = 32'(base + i); sl[2] = (i == len - 1);
      #1;
      if (mv[2] && mr[2]) begin
        n_vec++;
        if (first < 0) begin
          first = cyc; first_lvl = int'(lvl[2]);
        end
        popped++;
        if (q2.size() == 0) begin
          n_err++;
          $display("FAIL m2_data: got %h want <no beat>", {ml[2], mp[2]});
        end else begin
          e = q2.pop_front();
          if ({ml[2], mp[2]} !== e) begin
            n_err++;
            $display("FAIL m2_data: got %h want %h", {ml[2], mp[2]}, e);
          end
        end
      end
      if (sv[2] && sr[2]) begin
        q2.push_back({sl[2], sp[2]});
        i++;
      end
      cyc++;
    end
    sv[2] = 1'b0;
    n_vec++;
    if (first != want_first || first_lvl != want_lvl) begin
      n_err++;
      $display("FAIL m2_first_out len=%0d: got cycle %0d level %0d want cycle %0d level %0d",
               len, first, first_lvl, want_first, want_lvl);
    end
    n_vec++;
    if (popped != len || q2.size() != 0) begin
      n_err++;
      $display("FAIL m2_count len=%0d: got %0d popped, %0d left", len, popped, q2.size());
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (lvl[2] !== 5'd0 || mv[2] !== 1'b0) begin
      n_err++;
      $display("FAIL m2_empty: got level=%0d valid=%b want 0/0", lvl[2], mv[2]);
    end
  endtask

  task automatic test_reset_mid_burst();
    mr[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      sv[2] = 1'b1; sp[2] = 32'(3000 + c); sl[2] = 1'b0;
    end
    @(negedge clk);
    sv[2] = 1'b0;
    #1;
    n_vec++;
    if (lvl[2] !== 5'd3 || mv[2] !== 1'b0) begin
      n_err++;
      $display("FAIL m2_partial: got level=%0d valid=%b want 3/0", lvl[2], mv[2]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (lvl[2] !== 5'd0 || mv[2] !== 1'b0 || sr[2] !== 1'b0) begin
      n_err++;
      $display("FAIL m2_mid_reset: got level=%0d valid=%b ready=%b want 0/0/0",
               lvl[2], mv[2], sr[2]);
    end
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_mode2_burst(4, 4000, 4, 4);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0; sl[k] = 1'b0; sp[k] = '0; mr[k] = 1'b0;
    end
    test_reset();
    test_mode0_stream(0, -1);
    test_mode0_stream(100, 10);
    test_mode1_fill();
    test_mode1_wrap();
    test_mode2_burst(4, 500, 4, 4);
    test_mode2_burst(20, 600, 17, 16);
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
